// File: rtl/apf_video_out.sv
// APF scaler output stage: single-period hs/vs pulses with a vs-to-hs gap, registered DE/RGB,
// and per-frame active width/height measurement. Optional scanline dimming via APF_VIDEO_SCANLINES_EN.
`timescale 1ns / 1ps

module apf_video_out #(
  parameter int unsigned VS_HS_GAP = 3,
  parameter int unsigned CNT_W     = 9
) (
  input  logic             clk_vid,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             hbl_in,
  input  logic             vbl_in,
  input  logic [7:0]       r_in,
  input  logic [7:0]       g_in,
  input  logic [7:0]       b_in,
  input  logic             scanline_en,
  output logic [23:0]      vid_rgb,
  output logic             vid_de,
  output logic             vid_hs,
  output logic             vid_vs,
  output logic [CNT_W-1:0] act_width,
  output logic [CNT_W-1:0] act_lines
);

  localparam logic [3:0]       GapLoad = 4'(VS_HS_GAP);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [0:0] {StIdle, StGap} state_e;

  state_e           state_q;
  logic [3:0]       gap_cnt_q;
  logic             pending_hs_q;
  logic             vid_hs_q, vid_vs_q, vid_de_q, vid_de_d;
  logic [23:0]      vid_rgb_q, vid_rgb_d;
  logic             old_hs_q, old_vs_q, old_de_q;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] act_width_q, act_width_d;
  logic [CNT_W-1:0] act_lines_q, act_lines_d;
  logic [CNT_W-1:0] lines_inc;
  logic             de, hs_rise, vs_rise, de_fall;
  logic [23:0]      rgb_px;

  assign de      = ~hbl_in & ~vbl_in;
  assign hs_rise = hs_in & ~old_hs_q;
  assign vs_rise = vs_in & ~old_vs_q;
  // A real DE fall always follows at least one counted pixel; this masks the reset-time history.
  assign de_fall = old_de_q & ~de & (pix_cnt_q != '0);

`ifdef APF_VIDEO_SCANLINES_EN
  function automatic logic [7:0] dim(input logic [7:0] c);
    return {1'b0, c[7:1]} + {2'b00, c[7:2]};
  endfunction

  always_comb begin
    rgb_px = {r_in, g_in, b_in};
    if (scanline_en && line_cnt_q[0]) rgb_px = {dim(r_in), dim(g_in), dim(b_in)};
  end
`else
  logic unused_scanline_en;
  assign unused_scanline_en = scanline_en;
  assign rgb_px = {r_in, g_in, b_in};
`endif

  always_comb begin
    vid_de_d    = de;
    vid_rgb_d   = de ? rgb_px : 24'h0;
    pix_cnt_d   = pix_cnt_q;
    act_width_d = act_width_q;
    act_lines_d = act_lines_q;
    if (de) begin
      if (pix_cnt_q != CntMax) pix_cnt_d = pix_cnt_q + 1'b1;
    end else if (de_fall) begin
      act_width_d = pix_cnt_q;
      pix_cnt_d   = '0;
    end
    lines_inc = (de_fall && (line_cnt_q != CntMax)) ? line_cnt_q + 1'b1 : line_cnt_q;
    if (vs_rise) begin
      act_lines_d = lines_inc;
      line_cnt_d  = '0;
    end else begin
      line_cnt_d  = lines_inc;
    end
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      vid_de_q    <= 1'b0;
      vid_rgb_q   <= 24'h0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      act_width_q <= '0;
      act_lines_q <= '0;
      old_hs_q    <= 1'b1;
      old_vs_q    <= 1'b1;
      old_de_q    <= 1'b1;
    end else if (ce_pix) begin
      vid_de_q    <= vid_de_d;
      vid_rgb_q   <= vid_rgb_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      act_width_q <= act_width_d;
      act_lines_q <= act_lines_d;
      old_hs_q    <= hs_in;
      old_vs_q    <= vs_in;
      old_de_q    <= de;
    end
  end

  // Sync FSM: vs always wins; hs rises inside the gap collapse into one deferred pulse.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      gap_cnt_q    <= 4'd0;
      pending_hs_q <= 1'b0;
      vid_hs_q     <= 1'b0;
      vid_vs_q     <= 1'b0;
    end else if (ce_pix) begin
      vid_hs_q <= 1'b0;
      vid_vs_q <= 1'b0;
      if (vs_rise) begin
        vid_vs_q     <= 1'b1;
        gap_cnt_q    <= GapLoad;
        state_q      <= StGap;
        pending_hs_q <= pending_hs_q | hs_rise;
      end else begin
        case (state_q)
          StIdle: vid_hs_q <= hs_rise;
          StGap: begin
            if (gap_cnt_q <= 4'd1) begin
              state_q      <= StIdle;
              gap_cnt_q    <= 4'd0;
              vid_hs_q     <= pending_hs_q | hs_rise;
              pending_hs_q <= 1'b0;
            end else begin
              gap_cnt_q    <= gap_cnt_q - 4'd1;
              pending_hs_q <= pending_hs_q | hs_rise;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign vid_rgb   = vid_rgb_q;
  assign vid_de    = vid_de_q;
  assign vid_hs    = vid_hs_q;
  assign vid_vs    = vid_vs_q;
  assign act_width = act_width_q;
  assign act_lines = act_lines_q;

endmodule

// File: tb/tb_apf_video_out.sv
// Scoreboard bench for apf_video_out: each pixel step pushes its expected outputs, which are
// popped and compared one ce_pix later after an idle clock (so holding is also exercised).
`timescale 1ns / 1ps

module tb_apf_video_out;

  localparam int unsigned CntW   = 9;
  localparam int unsigned CntMax = (1 << CntW) - 1;

  typedef struct packed {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
  } exp_t;

  logic            clk_vid = 1'b0;
  logic            reset_n = 1'b0;
  logic            ce_pix = 1'b0;
  logic            hs_in = 1'b1, vs_in = 1'b1, hbl_in = 1'b1, vbl_in = 1'b1;
  logic [7:0]      r_in = '0, g_in = '0, b_in = '0;
  logic            scanline_en = 1'b0;
  logic [23:0]     vid_rgb;
  logic            vid_de, vid_hs, vid_vs;
  logic [CntW-1:0] act_width, act_lines;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk_vid = ~clk_vid;

  apf_video_out #(.VS_HS_GAP(3), .CNT_W(CntW)) dut (
    .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix),
    .hs_in(hs_in), .vs_in(vs_in), .hbl_in(hbl_in), .vbl_in(vbl_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .scanline_en(scanline_en),
    .vid_rgb(vid_rgb), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .act_width(act_width), .act_lines(act_lines)
  );

  function automatic logic [23:0] exp_px(input logic [23:0] c, input int line);
`ifdef APF_VIDEO_SCANLINES_EN
    if (scanline_en && (line % 2 == 1))
      return {8'(c[23:16] / 2 + c[23:16] / 4), 8'(c[15:8] / 2 + c[15:8] / 4),
              8'(c[7:0] / 2 + c[7:0] / 4)};
`endif
    return c;
  endfunction

  // Drive one pixel, record its expectation, then let one ce_pix edge and one idle edge pass.
  task automatic drive(input logic hs, input logic vs, input logic hbl, input logic vbl,
                       input logic [23:0] rgb, input logic [23:0] exp_rgb,
                       input logic exp_hs, input logic exp_vs);
    exp_t e;
    hs_in = hs; vs_in = vs; hbl_in = hbl; vbl_in = vbl;
    {r_in, g_in, b_in} = rgb;
    e.de  = ~hbl & ~vbl;
    e.rgb = e.de ? exp_rgb : 24'h0;
    e.hs  = exp_hs;
    e.vs  = exp_vs;
    sb.push_back(e);
    ce_pix = 1'b1;
    @(posedge clk_vid); #1;
    ce_pix = 1'b0;
    @(posedge clk_vid); #1;
  endtask

  task automatic test_reset;
    exp_t e;
    reset_n = 1'b0;
    repeat (3) @(posedge clk_vid);
    #1;
    n_cmp++;
    if ({vid_rgb, vid_de, vid_hs, vid_vs, act_width, act_lines} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: got rgb=%h de=%b hs=%b vs=%b w=%0d l=%0d, want all 0",
               vid_rgb, vid_de, vid_hs, vid_vs, act_width, act_lines);
    end
    reset_n = 1'b1;
    @(posedge clk_vid); #1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 24'hABCDEF, 24'hABCDEF, 1'b0, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if ({vid_rgb, vid_de, vid_hs, vid_vs, act_width, act_lines} !== {e, 18'h0}) begin
      n_err++;
      $display("FAIL reset_release: got rgb=%h de=%b hs=%b vs=%b w=%0d l=%0d, want all 0",
               vid_rgb, vid_de, vid_hs, vid_vs, act_width, act_lines);
    end
  endtask

  task automatic test_rgb_de;
    exp_t        e;
    logic [23:0] tbl[5] = '{24'h123456, 24'h123456, 24'hA5C3FF, 24'h000001, 24'hFFFFFF};
    logic [4:0]  hbl_v = 5'b00010;
    logic [4:0]  vbl_v = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, hbl_v[i], vbl_v[i], tbl[i], tbl[i], 1'b0, 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if ({vid_rgb, vid_de, vid_hs, vid_vs} !== e) begin
        n_err++;
        $display("FAIL rgb_de step %0d: got rgb=%h de=%b hs=%b vs=%b, want rgb=%h de=%b hs=%b vs=%b",
                 i, vid_rgb, vid_de, vid_hs, vid_vs, e.rgb, e.de, e.hs, e.vs);
      end
    end
    n_cmp++;
    if (act_width !== 9'd2) begin
      n_err++;
      $display("FAIL rgb_de_width: got %0d, want 2", act_width);
    end
  endtask

  task automatic test_gap;
    exp_t       e;
    logic [5:0] vs_v = 6'b000011, hs_v = 6'b000010;
    logic [5:0] evs_v = 6'b000001, ehs_v = 6'b001000;
    for (int i = 0; i < 6; i++) begin
      drive(hs_v[i], vs_v[i], 1'b1, 1'b1, 24'h0, 24'h0, ehs_v[i], evs_v[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({vid_rgb, vid_de, vid_hs, vid_vs} !== e) begin
        n_err++;
        $display("FAIL gap step %0d: got hs=%b vs=%b de=%b, want hs=%b vs=%b de=%b",
                 i, vid_hs, vid_vs, vid_de, e.hs, e.vs, e.de);
      end
    end
  endtask

  task automatic test_same_rise;
    exp_t       e;
    logic [7:0] vs_v = 8'b00000001, hs_v = 8'b00100101;
    logic [7:0] evs_v = 8'b00000001, ehs_v = 8'b00101000;
    for (int i = 0; i < 8; i++) begin
      drive(hs_v[i], vs_v[i], 1'b1, 1'b1, 24'h0, 24'h0, ehs_v[i], evs_v[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({vid_rgb, vid_de, vid_hs, vid_vs} !== e) begin
        n_err++;
        $display("FAIL same_rise step %0d: got hs=%b vs=%b, want hs=%b vs=%b",
                 i, vid_hs, vid_vs, e.hs, e.vs);
      end
    end
  endtask

  task automatic test_vs_reload;
    exp_t       e;
    logic [7:0] vs_v = 8'b00000101, hs_v = 8'b00000010;
    logic [7:0] evs_v = 8'b00000101, ehs_v = 8'b00100000;
    for (int i = 0; i < 8; i++) begin
      drive(hs_v[i], vs_v[i], 1'b1, 1'b1, 24'h0, 24'h0, ehs_v[i], evs_v[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({vid_rgb, vid_de, vid_hs, vid_vs} !== e) begin
        n_err++;
        $display("FAIL vs_reload step %0d: got hs=%b vs=%b, want hs=%b vs=%b",
                 i, vid_hs, vid_vs, e.hs, e.vs);
      end
    end
  endtask

  // 144 lines x 160 DE pixels; each line is hs-blank, blank, 160 active, blank.
  task automatic test_frame;
    exp_t        e;
    logic [23:0] px;
    logic        act;
    scanline_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, i == 0, 1'b1, 1'b1, 24'h0, 24'h0, 1'b0, i == 0);
      e = sb.pop_front();
      n_cmp++;
      if ({vid_rgb, vid_de, vid_hs, vid_vs} !== e) begin
        n_err++;
        $display("FAIL frame_start step %0d: got hs=%b vs=%b, want hs=%b vs=%b",
                 i, vid_hs, vid_vs, e.hs, e.vs);
      end
    end
    for (int l = 0; l < 144; l++) begin
      for (int s = 0; s < 163; s++) begin
        act = (s >= 2) && (s < 162);
        px  = {8'hFF, 8'(l), 8'(s - 2)};
        drive(s == 0, 1'b0, ~act, 1'b0, px, exp_px(px, l), s == 0, 1'b0);
        e = sb.pop_front();
        n_cmp++;
        if ({vid_rgb, vid_de, vid_hs, vid_vs} !== e) begin
          n_err++;
          $display("FAIL frame line %0d step %0d: got rgb=%h de=%b hs=%b, want rgb=%h de=%b hs=%b",
                   l, s, vid_rgb, vid_de, vid_hs, e.rgb, e.de, e.hs);
        end
      end
      if (l == 0) begin
        n_cmp++;
        if (act_width !== 9'd160) begin
          n_err++;
          $display("FAIL frame_width_first: got %0d, want 160", act_width);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, i == 0, 1'b1, 1'b1, 24'h0, 24'h0, 1'b0, i == 0);
      e = sb.pop_front();
      n_cmp++;
      if ({vid_rgb, vid_de, vid_hs, vid_vs} !== e) begin
        n_err++;
        $display("FAIL frame_end step %0d: got hs=%b vs=%b, want hs=%b vs=%b",
                 i, vid_hs, vid_vs, e.hs, e.vs);
      end
      if (i == 0) begin
        n_cmp++;
        if ({act_lines, act_width} !== {9'd144, 9'd160}) begin
          n_err++;
          $display("FAIL frame_lines: got lines=%0d width=%0d, want 144 / 160",
                   act_lines, act_width);
        end
      end
    end
    scanline_en = 1'b0;
  endtask

  // 600-pixel line, then 520 one-pixel lines, then vs: both counters pin at all-ones.
  task automatic test_saturate;
    exp_t        e;
    logic        act, vs;
    logic [23:0] px;
    int          last = 600 + 1 + 1040;
    for (int i = 0; i < last + 4; i++) begin
      act = (i < 600) || ((i > 600) && (i < last) && ((i - 601) % 2 == 0));
      vs  = (i == last);
      px  = 24'(i * 24'h010203);
      drive(1'b0, vs, ~act, 1'b0, px, px, 1'b0, vs);
      e = sb.pop_front();
      n_cmp++;
      if ({vid_rgb, vid_de, vid_hs, vid_vs} !== e) begin
        n_err++;
        $display("FAIL saturate step %0d: got rgb=%h de=%b vs=%b, want rgb=%h de=%b vs=%b",
                 i, vid_rgb, vid_de, vid_vs, e.rgb, e.de, e.vs);
      end
      if (i == 600) begin
        n_cmp++;
        if (act_width !== 9'(CntMax)) begin
          n_err++;
          $display("FAIL saturate_width: got %0d, want %0d", act_width, CntMax);
        end
      end
      if (i == last) begin
        n_cmp++;
        if (act_lines !== 9'(CntMax)) begin
          n_err++;
          $display("FAIL saturate_lines: got %0d, want %0d", act_lines, CntMax);
        end
      end
    end
  endtask

  task automatic test_reset_midline;
    exp_t e;
    logic act, vs;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h111111, 24'h111111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) void'(sb.pop_front());
    reset_n = 1'b0;
    @(posedge clk_vid); #1;
    n_cmp++;
    if ({vid_rgb, vid_de, vid_hs, vid_vs, act_width, act_lines} !== '0) begin
      n_err++;
      $display("FAIL midline_reset: got rgb=%h de=%b w=%0d l=%0d, want all 0",
               vid_rgb, vid_de, act_width, act_lines);
    end
    reset_n = 1'b1;
    @(posedge clk_vid); #1;
    // blank, 5 active, blank, vs, 3 blank
    for (int i = 0; i < 11; i++) begin
      act = (i >= 1) && (i <= 5);
      vs  = (i == 7);
      drive(1'b0, vs, ~act, 1'b0, 24'h00FF00, 24'h00FF00, 1'b0, vs);
      e = sb.pop_front();
      n_cmp++;
      if ({vid_rgb, vid_de, vid_hs, vid_vs} !== e) begin
        n_err++;
        $display("FAIL midline step %0d: got rgb=%h de=%b vs=%b, want rgb=%h de=%b vs=%b",
                 i, vid_rgb, vid_de, vid_vs, e.rgb, e.de, e.vs);
      end
      if (i == 7) begin
        n_cmp++;
        if ({act_width, act_lines} !== {9'd5, 9'd1}) begin
          n_err++;
          $display("FAIL midline_counts: got width=%0d lines=%0d, want 5 / 1",
                   act_width, act_lines);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rgb_de();
    test_gap();
    test_same_rise();
    test_vs_reload();
    test_frame();
    test_saturate();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
